fir_tap_sequencer: RTL and testbench

Control sequencer for the time-multiplexed FIR datapath. It accepts one deserialized sample per handshake and writes it into the circular sample buffer. It then steps the sample-buffer and coefficient-ROM addresses for the NUM_PIPELINES parallel MAC lanes over FIR_DEPTH/NUM_PIPELINES beats, waits out the MAC pipeline latency, and presents the result to the output serializer with a valid/ready handshake. It sits between the serial-input deserializer and the serial-output serializer and owns all datapath strobes.

---
 rtl/fir_tap_sequencer_if.sv | 49 ++++
 rtl/fir_tap_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
// Handshake and datapath-strobe bundle between the FIR tap sequencer and its
// deserializer, sample buffer, coefficient ROM, MAC lanes and output serializer.
interface fir_tap_sequencer_if #(
    parameter int FIR_DEPTH     = 256,
    parameter int NUM_PIPELINES = 8
) ();
    localparam int ADDR_WIDTH = $clog2(FIR_DEPTH);

    logic                                  i_sample_valid;
    logic                                  o_sample_ready;
    logic                                  o_wr_en;
    logic [ADDR_WIDTH-1:0]                 o_wr_addr;
    logic [NUM_PIPELINES*ADDR_WIDTH-1:0]   o_rd_addr;
    logic [ADDR_WIDTH-1:0]                 o_coef_addr;
    logic                                  o_mac_clr;
    logic                                  o_mac_en;
    logic                                  o_result_valid;
    logic                                  i_result_ready;
    logic                                  o_busy;

    // The sequencer owns every strobe, so it is the master side.
    modport master (
        input  i_sample_valid,
        input  i_result_ready,
        output o_sample_ready,
        output o_wr_en,
        output o_wr_addr,
        output o_rd_addr,
        output o_coef_addr,
        output o_mac_clr,
        output o_mac_en,
        output o_result_valid,
        output o_busy
    );

    modport slave (
        output i_sample_valid,
        output i_result_ready,
        input  o_sample_ready,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_rd_addr,
        input  o_coef_addr,
        input  o_mac_clr,
        input  o_mac_en,
        input  o_result_valid,
        input  o_busy
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a time-multiplexed FIR: sample write, lane-parallel MAC
// beats, pipeline drain and result handshake. Optional macro
// FIR_TAP_SEQUENCER_OVERRUN_CNT_EN adds a saturating overrun counter port.
module fir_tap_sequencer #(
    parameter int FIR_DEPTH     = 256,
    parameter int NUM_PIPELINES = 8,
    parameter int MAC_LATENCY   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    fir_tap_sequencer_if.master    bus
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
    ,
    output logic [15:0]            o_overrun_cnt
`endif
);
    localparam int ADDR_WIDTH = $clog2(FIR_DEPTH);
    localparam int BEATS      = FIR_DEPTH / NUM_PIPELINES;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DRAIN_W    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam int RD_W       = NUM_PIPELINES * ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        MAC    = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  head_reg, head_next;
    logic [BEAT_W-1:0]      beat_reg, beat_next;
    logic [DRAIN_W-1:0]     drain_reg, drain_next;
    logic                   armed_reg, armed_next;
    logic [RD_W-1:0]        rd_addr_reg, rd_addr_next;
    logic [ADDR_WIDTH-1:0]  coef_addr_reg, coef_addr_next;

    logic                   sample_ready;
    logic                   wr_en;
    logic                   mac_en;
    logic                   mac_clr;
    logic                   result_valid;
    logic [ADDR_WIDTH-1:0]  coef_base;
    logic [RD_W-1:0]        lane_addr;

    // Coefficient base of the current beat; beat*NUM_PIPELINES never exceeds FIR_DEPTH-1.
    assign coef_base = ADDR_WIDTH'(int'(beat_reg) * NUM_PIPELINES);

    // Lane k reads the sample k taps older than the beat's base tap; wraps naturally.
    for (genvar gi = 0; gi < NUM_PIPELINES; gi++) begin : g_lane
        assign lane_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            head_reg - coef_base - ADDR_WIDTH'(gi);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            head_reg      <= '0;
            beat_reg      <= '0;
            drain_reg     <= '0;
            armed_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            coef_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            beat_reg      <= beat_next;
            drain_reg     <= drain_next;
            armed_reg     <= armed_next;
            rd_addr_reg   <= rd_addr_next;
            coef_addr_reg <= coef_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        head_next      = head_reg;
        beat_next      = beat_reg;
        drain_next     = drain_reg;
        armed_next     = 1'b1;
        rd_addr_next   = rd_addr_reg;
        coef_addr_next = coef_addr_reg;
        sample_ready   = 1'b0;
        wr_en          = 1'b0;
        mac_en         = 1'b0;
        mac_clr        = 1'b0;
        result_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                sample_ready = armed_reg & i_en;
                if (sample_ready && bus.i_sample_valid) begin
                    head_next  = head_reg + ADDR_WIDTH'(1);
                    state_next = WRITE;
                end
            end

            WRITE: begin
                wr_en = i_en;
                if (i_en) begin
                    beat_next  = '0;
                    state_next = MAC;
                end
            end

            MAC: begin
                // Addresses track the frozen beat while stalled, so a resumed beat sees the same taps.
                mac_en         = i_en;
                mac_clr        = i_en && (beat_reg == '0);
                rd_addr_next   = lane_addr;
                coef_addr_next = coef_base;
                if (i_en) begin
                    if (beat_reg == BEAT_W'(BEATS - 1)) begin
                        if (MAC_LATENCY == 0) begin
                            state_next = OUTPUT;
                        end else begin
                            drain_next = '0;
                            state_next = DRAIN;
                        end
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (i_en) begin
                    if (drain_reg == DRAIN_W'(MAC_LATENCY - 1)) begin
                        state_next = OUTPUT;
                    end else begin
                        drain_next = drain_reg + DRAIN_W'(1);
                    end
                end
            end

            OUTPUT: begin
                // The result handshake deliberately ignores i_en so a stalled core still drains.
                result_valid = 1'b1;
                if (bus.i_result_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_sample_ready = sample_ready;
    assign bus.o_wr_en        = wr_en;
    assign bus.o_wr_addr      = head_reg;
    assign bus.o_rd_addr      = rd_addr_next;
    assign bus.o_coef_addr    = coef_addr_next;
    assign bus.o_mac_clr      = mac_clr;
    assign bus.o_mac_en       = mac_en;
    assign bus.o_result_valid = result_valid;
    assign bus.o_busy         = (state_reg != IDLE);

`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_reg;

    // Counts cycles in which the deserializer offers a sample the sequencer cannot take.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_cnt_reg <= '0;
        end else if (i_en && bus.i_sample_valid && (state_reg != IDLE)
                     && (overrun_cnt_reg != 16'hFFFF)) begin
            overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
        end
    end

    assign o_overrun_cnt = overrun_cnt_reg;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: table-driven timeline checks, directed
// corner sequences and a randomized run against a transaction-queue reference model.
module tb_fir_tap_sequencer;
    localparam int D     = 256;
    localparam int NP    = 8;
    localparam int ML    = 3;
    localparam int AW    = 8;
    localparam int BEATS = D / NP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.FIR_DEPTH(D), .NUM_PIPELINES(NP)) bus ();

`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
    logic [15:0] ovr;
`endif

    fir_tap_sequencer #(
        .FIR_DEPTH(D), .NUM_PIPELINES(NP), .MAC_LATENCY(ML)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .bus     (bus)
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
        ,
        .o_overrun_cnt (ovr)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one queue entry per enabled cycle of work still owed
    // (kind*256+beat; kind 0=write, 1=MAC beat, 2=drain, 3=result).
    int              q[$];
    int              m_head  = 0;
    bit              m_armed = 1'b0;
    logic [63:0]     m_rd    = '0;
    int              m_coef  = 0;
    int              m_ovr   = 0;

    always @(negedge clk) begin
        int kind, b;
        logic e_sready, e_wr, e_mac, e_clr, e_val, e_busy;
        if (!rst_n) begin
            q.delete();
            m_head = 0; m_armed = 1'b0; m_rd = '0; m_coef = 0; m_ovr = 0;
            chk("rst_sready", bus.o_sample_ready, 0);
            chk("rst_strobes", {bus.o_wr_en, bus.o_mac_en, bus.o_mac_clr, bus.o_result_valid, bus.o_busy}, 0);
            chk("rst_addr", {bus.o_wr_addr, bus.o_coef_addr, bus.o_rd_addr}, 0);
        end else begin
            kind = (q.size() != 0) ? q[0] / 256 : -1;
            b    = (q.size() != 0) ? q[0] % 256 : 0;
            e_sready = (q.size() == 0) && m_armed && en;
            e_wr   = en && (kind == 0);
            e_mac  = en && (kind == 1);
            e_clr  = e_mac && (b == 0);
            e_val  = (kind == 3);
            e_busy = (q.size() != 0);
            if (kind == 1) begin
                for (int k = 0; k < NP; k++) m_rd[k*AW +: AW] = AW'((m_head - b*NP - k) & (D-1));
                m_coef = b * NP;
            end
            chk("m_sready", bus.o_sample_ready, e_sready);
            chk("m_wr_en", bus.o_wr_en, e_wr);
            chk("m_mac_en", bus.o_mac_en, e_mac);
            chk("m_mac_clr", bus.o_mac_clr, e_clr);
            chk("m_valid", bus.o_result_valid, e_val);
            chk("m_busy", bus.o_busy, e_busy);
            chk("m_rd_addr", bus.o_rd_addr, m_rd);
            chk("m_coef", bus.o_coef_addr, m_coef);
            if (e_wr) chk("m_wr_addr", bus.o_wr_addr, m_head);
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
            chk("m_ovr", ovr, m_ovr);
            if (en && bus.i_sample_valid && q.size() != 0 && m_ovr < 65535) m_ovr++;
`endif
            if (q.size() == 0) begin
                if (e_sready && bus.i_sample_valid) begin
                    m_head = (m_head + 1) % D;
                    q.push_back(0);
                    for (int j = 0; j < BEATS; j++) q.push_back(256 + j);
                    for (int j = 0; j < ML; j++) q.push_back(512);
                    q.push_back(768);
                end
            end else if (kind == 3) begin
                if (bus.i_result_ready) void'(q.pop_front());
            end else if (en) begin
                void'(q.pop_front());
            end
            m_armed = 1'b1;
        end
    end

    // Per-cycle observations of one transaction, indexed by cycle after the accept edge.
    logic        obs_wr[0:63], obs_mac[0:63], obs_clr[0:63], obs_val[0:63], obs_busy[0:63], obs_sready[0:63];
    logic [7:0]  obs_wraddr[0:63], obs_coef[0:63];
    logic [63:0] obs_rd[0:63];
    int          n_acc = 0;

    task automatic accept();
        int guard;
        @(posedge clk); #1;
        en = 1'b1; bus.i_sample_valid = 1'b1; bus.i_result_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bus.o_sample_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", bus.o_sample_ready, 1);
        @(posedge clk); #1;
        bus.i_sample_valid = 1'b0;
        n_acc++;
    endtask

    task automatic timeline(input int ncyc, input int stall_start, input int stall_len,
                            input int valid_until, input int ready_low_until,
                            output int first_valid, output int mac_cnt);
        first_valid = 0;
        mac_cnt = 0;
        accept();
        for (int n = 1; n <= ncyc; n++) begin
            en = !(n >= stall_start && n < stall_start + stall_len);
            bus.i_sample_valid = (n <= valid_until);
            bus.i_result_ready = (n > ready_low_until);
            @(negedge clk);
            obs_wr[n] = bus.o_wr_en;     obs_mac[n] = bus.o_mac_en;  obs_clr[n] = bus.o_mac_clr;
            obs_val[n] = bus.o_result_valid; obs_busy[n] = bus.o_busy; obs_sready[n] = bus.o_sample_ready;
            obs_wraddr[n] = bus.o_wr_addr; obs_coef[n] = bus.o_coef_addr; obs_rd[n] = bus.o_rd_addr;
            if (bus.o_mac_en) mac_cnt++;
            if (bus.o_result_valid && first_valid == 0) first_valid = n;
            @(posedge clk); #1;
        end
        bus.i_sample_valid = 1'b0; bus.i_result_ready = 1'b1; en = 1'b1;
    endtask

    typedef struct {
        int   n;
        logic wr, mac, clr, val, busy;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int fv, mc, cnt, cnt2;
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
        int ovr0;
`endif
        tbl[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{37, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{38, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.i_sample_valid = 1'b0; bus.i_result_ready = 1'b1; en = 1'b1; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("armed_delay", bus.o_sample_ready, 0);
        @(negedge clk);
        chk("ready_after_release", bus.o_sample_ready, 1);

        // Single sample, defaults, table-driven.
        timeline(45, 0, 0, 0, 0, fv, mc);
        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d_wr", tbl[i].n),   obs_wr[tbl[i].n],   tbl[i].wr);
            chk($sformatf("tbl%0d_mac", tbl[i].n),  obs_mac[tbl[i].n],  tbl[i].mac);
            chk($sformatf("tbl%0d_clr", tbl[i].n),  obs_clr[tbl[i].n],  tbl[i].clr);
            chk($sformatf("tbl%0d_val", tbl[i].n),  obs_val[tbl[i].n],  tbl[i].val);
            chk($sformatf("tbl%0d_busy", tbl[i].n), obs_busy[tbl[i].n], tbl[i].busy);
        end
        chk("first_wr_addr", obs_wraddr[1], 1);
        chk("single_mac_cnt", mc, 32);
        chk("single_first_valid", fv, 37);
        $display("txn single: first_valid=%0d mac_cycles=%0d", fv, mc);

        // Addressing after five accepts.
        while (n_acc < 4) timeline(40, 0, 0, 0, 0, fv, mc);
        timeline(40, 0, 0, 0, 0, fv, mc);
        chk("addr_beat1_lane2", obs_rd[3][2*AW +: AW], 251);
        chk("addr_beat1_coef", obs_coef[3], 8);
        chk("addr_beat0_lane0", obs_rd[2][0 +: AW], 5);
        $display("txn addressing: head=%0d lane2=%0d", n_acc, obs_rd[3][2*AW +: AW]);

        // Enable stall for 4 cycles starting at MAC beat 5 (cycle 7).
        timeline(45, 7, 4, 0, 0, fv, mc);
        cnt = 0;
        for (int n = 7; n <= 10; n++) cnt += obs_mac[n];
        chk("stall_mac_off", cnt, 0);
        chk("stall_coef_hold", obs_coef[9], 40);
        chk("stall_rd_hold", obs_rd[9][0 +: AW], (6 - 40) & (D-1));
        chk("stall_mac_cnt", mc, 32);
        chk("stall_first_valid", fv, 41);
        $display("txn stall: first_valid=%0d mac_cycles=%0d", fv, mc);

        // Result backpressure with sample_valid held high.
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
        ovr0 = int'(ovr);
`endif
        timeline(50, 0, 0, 46, 46, fv, mc);
        cnt = 0; cnt2 = 0;
        for (int n = 37; n <= 46; n++) cnt += obs_val[n];
        for (int n = 1; n <= 46; n++) cnt2 += obs_sready[n];
        chk("bp_valid_held", cnt, 10);
        chk("bp_sready_low", cnt2, 0);
        chk("bp_idle_after", obs_busy[48], 0);
`ifdef FIR_TAP_SEQUENCER_OVERRUN_CNT_EN
        chk("bp_overrun", int'(ovr) - ovr0, 46);
`endif
        $display("txn backpressure: valid_cycles=%0d", cnt);

        // Head wrap.
        while (n_acc < 255) timeline(38, 0, 0, 0, 0, fv, mc);
        timeline(38, 0, 0, 0, 0, fv, mc);
        chk("wrap_256_addr", obs_wraddr[1], 0);
        timeline(38, 0, 0, 0, 0, fv, mc);
        chk("wrap_257_addr", obs_wraddr[1], 1);
        $display("txn wrap: accepts=%0d last_addr=%0d", n_acc, obs_wraddr[1]);

        // Reset during MAC beat 10 (cycle 12).
        accept();
        repeat (11) @(posedge clk);
        #1;
        chk("pre_rst_coef", bus.o_coef_addr, 80);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {bus.o_wr_en, bus.o_mac_en, bus.o_mac_clr, bus.o_result_valid, bus.o_busy, bus.o_sample_ready}, 0);
        chk("rst_mid_addr", {bus.o_wr_addr, bus.o_coef_addr, bus.o_rd_addr}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_ready", bus.o_sample_ready, 1);
        n_acc = 0;
        timeline(40, 0, 0, 0, 0, fv, mc);
        chk("rst_mid_first_wr", obs_wraddr[1], 1);
        $display("txn reset_mid_mac: first_wr=%0d", obs_wraddr[1]);

        // Randomized traffic, checked every cycle by the reference model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 7) != 0);
            bus.i_sample_valid = ($urandom_range(0, 2) == 0);
            bus.i_result_ready = ($urandom_range(0, 1) == 1);
            rst_n = !(c == 2000 || c == 2001);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; bus.i_sample_valid = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        $display("txn random: cycles=4000");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
